// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bundle between the pipeline and dmem_responder.
interface dmem_responder_if;
    logic        req, we, ready, misalign_err, pass, fail;
    logic [31:0] addr, wdata, rdata;
    modport master (output req, we, addr, wdata, input rdata, ready, misalign_err, pass, fail);
    modport slave (input req, we, addr, wdata, output rdata, ready, misalign_err, pass, fail);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM responder with LATENCY-cycle request-to-ready delay for the CPU load/store port.
// Defining DMEM_MONITOR_EN builds the pass/fail store monitor; otherwise pass/fail are tied low.
module dmem_responder #(
    parameter int          DEPTH      = 64,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd80
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t          state, state_nx;
    logic [2:0]      cnt;
    logic            l_we, c_we, aligned, commit, ready_c, misalign_q;
    logic [31:0]     l_addr, l_wdata, c_addr, c_wdata, rdata_q;
    logic [AW-1:0]   idx;
    logic [31:0]     mem [DEPTH];
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (bus.req ? ((LATENCY == 1) ? RESP : BUSY) : IDLE) :
                   (state == BUSY) ? ((cnt <= 3'd1) ? RESP : BUSY) : IDLE;
    end
    // With LATENCY=1 the commit edge is also the accept edge, so the live inputs stand in for the latches.
    always_comb begin
        c_we    = (state == IDLE) ? bus.we : l_we;
        c_addr  = (state == IDLE) ? bus.addr : l_addr;
        c_wdata = (state == IDLE) ? bus.wdata : l_wdata;
        aligned = c_addr[1:0] == 2'b00;
        idx     = c_addr[AW+1:2];
        ready_c = state == RESP;
        commit  = reset && state != RESP && state_nx == RESP;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt     <= '0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else if (state == IDLE && bus.req) begin
            cnt     <= 3'(LATENCY - 1);
            l_we    <= bus.we;
            l_addr  <= bus.addr;
            l_wdata <= bus.wdata;
        end else if (state == BUSY) begin
            cnt <= cnt - 3'd1;
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (commit) begin
            if (!c_we) rdata_q <= aligned ? mem[idx] : '0;
            if (!aligned) misalign_q <= 1'b1;
        end
    always_ff @(posedge clk)
        if (commit && c_we && aligned) mem[idx] <= c_wdata;
    assign bus.ready        = ready_c;
    assign bus.rdata        = rdata_q;
    assign bus.misalign_err = misalign_q;
`ifdef DMEM_MONITOR_EN
    logic pass_q, fail_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (commit && c_we && aligned && !pass_q && !fail_q) begin
            if (c_addr == PASS_ADDR && c_wdata == PASS_DATA) pass_q <= 1'b1;
            else if (c_addr != ALLOW_ADDR) fail_q <= 1'b1;
        end
    assign bus.pass = pass_q;
    assign bus.fail = fail_q;
`else
    logic unused_addr;
    assign unused_addr = ^c_addr[31:AW+2];
    assign bus.pass    = 1'b0;
    assign bus.fail    = 1'b0;
`endif
endmodule
